// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly: o1 = a + b*w, o2 = a - b*w.
// Optional per-beat halving with rounding, saturating outputs and a sticky overflow flag.
module butterfly_pipe #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] b_re,
    input  logic [DATA_W-1:0] b_im,
    input  logic [TW_W-1:0]   w_re,
    input  logic [TW_W-1:0]   w_im,
    input  logic              scale_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] o1_re,
    output logic [DATA_W-1:0] o1_im,
    output logic [DATA_W-1:0] o2_re,
    output logic [DATA_W-1:0] o2_im,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int PW = DATA_W + TW_W;

    localparam logic signed [PW:0]       RND     = (PW+1)'(1) << (TW_W - 2);
    localparam logic signed [DATA_W+1:0] ONE     = (DATA_W+2)'(1);
    localparam logic signed [DATA_W+1:0] SAT_MAX = (DATA_W+2)'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [DATA_W+1:0] SAT_MIN = ~SAT_MAX;

    logic advance;

    logic signed [PW-1:0] b_re_x, b_im_x, w_re_x, w_im_x;

    logic                     s1_valid, s1_scale;
    logic signed [DATA_W-1:0] s1_a_re, s1_a_im;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;

    logic                     s2_valid, s2_scale;
    logic signed [DATA_W-1:0] s2_a_re, s2_a_im;
    logic signed [DATA_W:0]   t_re, t_im, s2_t_re, s2_t_im;

    logic [DATA_W:0] r1_re, r1_im, r2_re, r2_im;
    logic            sat_any;

    // A stall anywhere freezes the whole pipe, so bubbles are never squeezed out.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign b_re_x = {{TW_W{b_re[DATA_W-1]}}, b_re};
    assign b_im_x = {{TW_W{b_im[DATA_W-1]}}, b_im};
    assign w_re_x = {{DATA_W{w_re[TW_W-1]}}, w_re};
    assign w_im_x = {{DATA_W{w_im[TW_W-1]}}, w_im};

    // Round-half-up back to Q0 and keep DATA_W+1 bits of the complex product.
    assign t_re = (DATA_W+1)'(($signed({p_rr[PW-1], p_rr}) - $signed({p_ii[PW-1], p_ii}) + RND)
                              >>> (TW_W - 1));
    assign t_im = (DATA_W+1)'(($signed({p_ri[PW-1], p_ri}) + $signed({p_ir[PW-1], p_ir}) + RND)
                              >>> (TW_W - 1));

    // Returns {saturated, value}.
    function automatic logic [DATA_W:0] finish_out(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W:0]   t,
        input logic                     sub,
        input logic                     sc
    );
        logic signed [DATA_W+1:0] s;
        s = sub ? ($signed({{2{a[DATA_W-1]}}, a}) - $signed({t[DATA_W], t}))
                : ($signed({{2{a[DATA_W-1]}}, a}) + $signed({t[DATA_W], t}));
        if (sc) s = (s + ONE) >>> 1;
        if (s > SAT_MAX) return {1'b1, SAT_MAX[DATA_W-1:0]};
        if (s < SAT_MIN) return {1'b1, SAT_MIN[DATA_W-1:0]};
        return {1'b0, s[DATA_W-1:0]};
    endfunction

    always_comb begin
        r1_re = finish_out(s2_a_re, s2_t_re, 1'b0, s2_scale);
        r1_im = finish_out(s2_a_im, s2_t_im, 1'b0, s2_scale);
        r2_re = finish_out(s2_a_re, s2_t_re, 1'b1, s2_scale);
        r2_im = finish_out(s2_a_im, s2_t_im, 1'b1, s2_scale);
    end

    assign sat_any = r1_re[DATA_W] | r1_im[DATA_W] | r2_re[DATA_W] | r2_im[DATA_W];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
        end
    end

    // NOTE: interior datapath flops have no reset; the stage valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_a_re  <= $signed(a_re);
            s1_a_im  <= $signed(a_im);
            s1_scale <= scale_en;
            p_rr     <= b_re_x * w_re_x;
            p_ii     <= b_im_x * w_im_x;
            p_ri     <= b_re_x * w_im_x;
            p_ir     <= b_im_x * w_re_x;
            s2_a_re  <= s1_a_re;
            s2_a_im  <= s1_a_im;
            s2_scale <= s1_scale;
            s2_t_re  <= t_re;
            s2_t_im  <= t_im;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            o1_re     <= '0;
            o1_im     <= '0;
            o2_re     <= '0;
            o2_im     <= '0;
            ovf       <= 1'b0;
        end else begin
            if (advance) begin
                out_valid <= s2_valid;
                o1_re     <= r1_re[DATA_W-1:0];
                o1_im     <= r1_im[DATA_W-1:0];
                o2_re     <= r2_re[DATA_W-1:0];
                o2_im     <= r2_im[DATA_W-1:0];
            end
            // A new saturation takes priority over a clear in the same cycle.
            if (advance && s2_valid && sat_any) ovf <= 1'b1;
            else if (ovf_clr)                   ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed corner beats, backpressure,
// randomized streaming against an arithmetic reference model, and mid-flight reset.
module tb_butterfly_pipe;

    localparam int DW = 16;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          in_valid, in_ready, scale_en, out_valid, out_ready, ovf, ovf_clr;
    logic [DW-1:0] a_re, a_im, b_re, b_im;
    logic [TW-1:0] w_re, w_im;
    logic [DW-1:0] o1_re, o1_im, o2_re, o2_im;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        longint are, aim, bre, bim, wre, wim;
        bit     sc;
    } beat_t;

    typedef struct {
        longint o1re, o1im, o2re, o2im;
        bit     sat;
    } res_t;

    beat_t in_q[$];
    res_t  exp_q[$];
    bit    model_ovf = 1'b0;
    int    p_valid   = 100;
    int    p_ready   = 100;
    int    acc_cnt   = 0;
    int    pop_cnt   = 0;

    butterfly_pipe #(.DATA_W(DW), .TW_W(TW)) dut (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .w_re(w_re), .w_im(w_im), .scale_en(scale_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .o1_re(o1_re), .o1_im(o1_im), .o2_re(o2_re), .o2_im(o2_im),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: exact complex arithmetic, round half up, DATA_W+1-bit product wrap, clamp.
    function automatic longint wrap_t(input longint v);
        longint m;
        m = v & ((64'sd1 <<< (DW + 1)) - 1);
        if (m >= (64'sd1 <<< DW)) m = m - (64'sd1 <<< (DW + 1));
        return m;
    endfunction

    function automatic longint clamp(input longint s, input bit sc, inout bit sat);
        longint hi, lo;
        hi = (64'sd1 <<< (DW - 1)) - 1;
        lo = -(64'sd1 <<< (DW - 1));
        if (sc) s = (s + 1) >>> 1;
        if (s > hi) begin sat = 1'b1; return hi; end
        if (s < lo) begin sat = 1'b1; return lo; end
        return s;
    endfunction

    function automatic res_t model(input beat_t b);
        res_t   r;
        longint tre, tim;
        bit     sat;
        sat  = 1'b0;
        tre  = wrap_t((b.bre * b.wre - b.bim * b.wim + (64'sd1 <<< (TW - 2))) >>> (TW - 1));
        tim  = wrap_t((b.bre * b.wim + b.bim * b.wre + (64'sd1 <<< (TW - 2))) >>> (TW - 1));
        r.o1re = clamp(b.are + tre, b.sc, sat);
        r.o1im = clamp(b.aim + tim, b.sc, sat);
        r.o2re = clamp(b.are - tre, b.sc, sat);
        r.o2im = clamp(b.aim - tim, b.sc, sat);
        r.sat  = sat;
        return r;
    endfunction

    function automatic longint rv(input int w);
        case ($urandom_range(7))
            0:       return -(64'sd1 <<< (w - 1));
            1:       return (64'sd1 <<< (w - 1)) - 1;
            default: return longint'($urandom_range((1 << w) - 1)) - (64'sd1 <<< (w - 1));
        endcase
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.are = rv(DW); b.aim = rv(DW);
        b.bre = rv(DW); b.bim = rv(DW);
        b.wre = rv(TW); b.wim = rv(TW);
        b.sc  = 1'($urandom_range(1));
        return b;
    endfunction

    task automatic drive(input beat_t b);
        a_re = DW'(b.are); a_im = DW'(b.aim);
        b_re = DW'(b.bre); b_im = DW'(b.bim);
        w_re = TW'(b.wre); w_im = TW'(b.wim);
        scale_en = b.sc;
    endtask

    function automatic beat_t mk(input longint ar, ai, br, bi, wr, wi, input bit sc);
        beat_t b;
        b.are = ar; b.aim = ai; b.bre = br; b.bim = bi; b.wre = wr; b.wim = wi; b.sc = sc;
        return b;
    endfunction

    // One clock of the scoreboard engine; entered and left at posedge+1.
    task automatic step();
        beat_t cur;
        res_t  e;
        bit    give;
        give = (in_q.size() > 0) && ($urandom_range(99) < p_valid);
        if (give) begin
            cur = in_q[0];
            drive(cur);
        end
        in_valid  = give;
        out_ready = ($urandom_range(99) < p_ready);
        #1;
        if (out_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("stale_out", out_valid, 0);
            end else begin
                e = exp_q[0];
                check("o1_re", $signed(o1_re), e.o1re);
                check("o1_im", $signed(o1_im), e.o1im);
                check("o2_re", $signed(o2_re), e.o2re);
                check("o2_im", $signed(o2_im), e.o2im);
                if (out_ready) begin
                    model_ovf = model_ovf | e.sat;
                    check("ovf_stream", ovf, model_ovf);
                    void'(exp_q.pop_front());
                    pop_cnt++;
                end
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(cur));
            void'(in_q.pop_front());
            acc_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, in_q.size() + exp_q.size(), 0);
    endtask

    // Single beat with explicit 3-cycle latency check; optional ovf_clr on the S3 load edge.
    task automatic directed(input string tag, input beat_t b,
                            input longint e1r, e1i, e2r, e2i, input bit e_ovf, input bit clr_at_load);
        drive(b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_lat2"}, out_valid, 0);
        ovf_clr = clr_at_load;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check({tag, "_lat3"}, out_valid, 1);
        check({tag, "_o1_re"}, $signed(o1_re), e1r);
        check({tag, "_o1_im"}, $signed(o1_im), e1i);
        check({tag, "_o2_re"}, $signed(o2_re), e2r);
        check({tag, "_o2_im"}, $signed(o2_im), e2i);
        check({tag, "_ovf"}, ovf, e_ovf);
        @(posedge clk); #1;
        check({tag, "_drained"}, out_valid, 0);
    endtask

    task automatic pulse_clr(input string tag);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        model_ovf = 1'b0;
        check(tag, ovf, 0);
    endtask

    initial begin
        n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; scale_en = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_o1_re", o1_re, 0);
        check("rst_o1_im", o1_im, 0);
        check("rst_o2_re", o2_re, 0);
        check("rst_o2_im", o2_im, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic
        directed("unity_tw", mk(5, 4, 3, 2, 32767, 0, 0), 8, 6, 2, 2, 0, 0);
        directed("minus_j",  mk(5, 4, 3, 2, 0, -32768, 0), 7, 1, 3, 7, 0, 0);
        directed("round_scale", mk(3, -3, 0, 0, 32767, 0, 1), 2, -1, 2, -1, 0, 0);
        directed("sat_pos",  mk(32767, 0, 32767, 0, 32767, 0, 0), 32767, 0, 1, 0, 1, 0);
        directed("sat_scaled", mk(32767, 0, 32767, 0, 32767, 0, 1), 32767, 0, 1, 0, 1, 0);
        pulse_clr("ovf_clr");
        directed("sat_neg_set_wins", mk(-32768, 0, 32767, 0, 32767, 0, 0), -2, 0, -32768, 0, 1, 1);
        pulse_clr("ovf_clr2");

        // Backpressure: pipe holds exactly three beats, outputs hold, then 1 beat/cycle
        for (int i = 0; i < 8; i++) in_q.push_back(rand_beat());
        p_valid = 100; p_ready = 0; acc_cnt = 0;
        for (int i = 0; i < 6; i++) step();
        check("stall_accepted", acc_cnt, 3);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        p_ready = 100; pop_cnt = 0;
        for (int i = 0; i < 8; i++) step();
        check("release_pops", pop_cnt, 8);
        check("release_empty", out_valid, 0);
        drain("release", 20);

        // Randomized streaming against the reference model
        pulse_clr("ovf_clr_rand");
        p_valid = 75; p_ready = 70; pop_cnt = 0;
        for (int i = 0; i < 10000; i++) in_q.push_back(rand_beat());
        drain("random", 60000);
        check("random_pops", pop_cnt, 10000);

        // Reset with beats in flight
        p_valid = 100; p_ready = 100;
        in_q.push_back(mk(32767, 0, 32767, 0, 32767, 0, 0));
        drain("pre_reset", 20);
        check("pre_reset_ovf", ovf, 1);
        in_q.push_back(rand_beat());
        in_q.push_back(rand_beat());
        step();
        step();
        in_valid = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_ovf", ovf, 0);
        in_q.delete();
        exp_q.delete();
        model_ovf = 1'b0;
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_quiet", out_valid, 0);
        end
        check("post_rst_ovf", ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
